// File: rtl/rca_wb_sequencer.sv
// rca_wb_sequencer: buffers multi-result RCA writebacks and drains them
// one word per grant into the single register-file write port.
module rca_wb_sequencer #(
  parameter int NUM_WRITE_PORTS = 5,
  parameter int XLEN            = 32,
  parameter int ID_WIDTH        = 3,
  parameter int BUF_DEPTH       = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  rca_wb_done,
  input  logic [ID_WIDTH-1:0]                   rca_wb_id,
  input  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]  rca_wb_rd,
  input  logic [NUM_WRITE_PORTS-1:0][4:0]       dest_addrs,
  output logic                                  rca_wb_ready,
  output logic                                  rf_we,
  output logic [4:0]                            rf_waddr,
  output logic [XLEN-1:0]                       rf_wdata,
  output logic [ID_WIDTH-1:0]                   rf_wid,
  input  logic                                  rf_gnt,
  output logic                                  retire_valid,
  output logic [ID_WIDTH-1:0]                   retire_id,
  output logic                                  overflow
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int PI = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;

  typedef logic [NUM_WRITE_PORTS-1:0][4:0]      addr_vec_t;
  typedef logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] data_vec_t;
  typedef enum logic [1:0] {IDLE, DRAIN, RETIRE} state_e;

  // {found, index} of the lowest nonzero address at or above start
  function automatic logic [PI:0] find_nz(input addr_vec_t a, input int start);
    logic [PI:0] r;
    r = '0;
    for (int i = NUM_WRITE_PORTS - 1; i >= 0; i--) begin
      if (i >= start && a[i] != 5'd0) r = {1'b1, PI'(i)};
    end
    return r;
  endfunction

  logic [ID_WIDTH-1:0] id_mem   [BUF_DEPTH];
  data_vec_t           rd_mem   [BUF_DEPTH];
  addr_vec_t           addr_mem [BUF_DEPTH];

  state_e        state_q, state_d;
  logic [PI-1:0] p_q, p_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          push, pop, more;
  logic [PI:0]   f;
  addr_vec_t     head_addrs, nxt_addrs;

  assign rca_wb_ready = (count_q != (PW+1)'(BUF_DEPTH));

  always_comb begin
    push       = rca_wb_done && rca_wb_ready;
    pop        = (state_q == RETIRE);
    more       = (count_q > (PW+1)'(1)) || push;
    head_addrs = addr_mem[rptr_q];
    // the entry behind the head is either buffered or arriving right now
    nxt_addrs  = (count_q > (PW+1)'(1)) ? addr_mem[rptr_q + PW'(1)]
                                        : dest_addrs;
    f          = '0;
    state_d    = state_q;
    p_d        = p_q;
    wptr_d     = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + PW'(1) : rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (rca_wb_done & ~rca_wb_ready);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    unique case (state_q)
      IDLE: begin
        if (count_q != '0 || push) begin
          f = find_nz((count_q != '0) ? head_addrs : dest_addrs, 0);
          state_d = f[PI] ? DRAIN : RETIRE;
          p_d     = f[PI] ? f[PI-1:0] : '0;
        end
      end
      DRAIN: begin
        if (rf_gnt) begin
          f = find_nz(head_addrs, int'(p_q) + 1);
          state_d = f[PI] ? DRAIN : RETIRE;
          p_d     = f[PI] ? f[PI-1:0] : '0;
        end
      end
      RETIRE: begin
        if (more) begin
          f = find_nz(nxt_addrs, 0);
          state_d = f[PI] ? DRAIN : RETIRE;
          p_d     = f[PI] ? f[PI-1:0] : '0;
        end else begin
          state_d = IDLE;
          p_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        p_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      p_q        <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wptr_q]   <= rca_wb_id;
      rd_mem[wptr_q]   <= rca_wb_rd;
      addr_mem[wptr_q] <= dest_addrs;
    end
  end

  assign rf_we        = (state_q == DRAIN);
  assign rf_waddr     = rf_we ? addr_mem[rptr_q][p_q] : 5'd0;
  assign rf_wdata     = rf_we ? rd_mem[rptr_q][p_q] : '0;
  assign rf_wid       = rf_we ? id_mem[rptr_q] : '0;
  assign retire_valid = (state_q == RETIRE);
  assign retire_id    = retire_valid ? id_mem[rptr_q] : '0;
  assign overflow     = overflow_q;

endmodule

// File: doc/rca_wb_sequencer.md
Name: rca_wb_sequencer

Overview:
Consumer end of the RCA writeback interface. Accepts a multi-result writeback (one id, NUM_WRITE_PORTS data words) together with the destination register addresses from the RCA config registers, and buffers it. It then drains the results one per grant into the single CPU register-file write port, and signals retirement of the id once the last result has been written. It sits between the RCA unit and the Taiga writeback/register-file logic.

Parameters:
NUM_WRITE_PORTS, 5, results per RCA writeback
XLEN, 32, data word width
ID_WIDTH, 3, instruction id width
BUF_DEPTH, 2, buffered writeback entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rca_wb_done  in  1  writeback valid pulse from RCA unit
rca_wb_id  in  ID_WIDTH  instruction id
rca_wb_rd  in  NUM_WRITE_PORTS x XLEN  result words, index 0 first
dest_addrs  in  NUM_WRITE_PORTS x 5  destination register per result, sampled with done
rca_wb_ready  out  1  buffer can accept this cycle
rf_we  out  1  register-file write request
rf_waddr  out  5  write address
rf_wdata  out  XLEN  write data
rf_wid  out  ID_WIDTH  id of the entry being written
rf_gnt  in  1  register file accepted current write
retire_valid  out  1  one-cycle pulse: entry fully written
retire_id  out  ID_WIDTH  retired id
overflow  out  1  sticky: done arrived while not ready

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: all outputs 0 except rca_wb_ready=1. FIFO is emptied, state=IDLE, port index=0, overflow=0. Asserting rst mid-drain discards all entries with no further rf_we or retire.
- Push:
  - rca_wb_done && rca_wb_ready stores {id, rd[], dest_addrs[]} at the FIFO tail.
  - rca_wb_ready = (count != BUF_DEPTH), computed from registered count only. A pop in the same cycle does not make a full buffer ready.
  - done while full: the entry is dropped and overflow is set until rst.
- FSM states: IDLE, DRAIN, RETIRE.
  - IDLE: if FIFO non-empty, go to DRAIN with port index p = first index with dest_addr != 0. If all addresses are 0, go directly to RETIRE.
  - DRAIN:
    - Outputs: rf_we=1, rf_waddr=addr[p], rf_wdata=rd[p], rf_wid=head id.
    - These outputs are held stable until rf_gnt.
    - On rf_gnt, p advances to the next index with nonzero address. If no such index remains, go to RETIRE.
    - Zero-address ports are skipped with no cycle spent. rf_we is never asserted with waddr=0.
  - RETIRE:
    - retire_valid=1 and retire_id=head id for exactly one cycle, with rf_we=0.
    - The head is popped in this cycle.
    - Next state is DRAIN (or RETIRE if the next entry is all-zero) if another entry is present, else IDLE.
- Latency, with rf_gnt tied 1 and an empty buffer, for a push at cycle T with k nonzero addresses:
  - rf_we is asserted in cycles T+1 .. T+k.
  - retire_valid is asserted in cycle T+k+1.
  - If k=0, retire_valid is asserted in cycle T+1.
- Ordering: entries retire in push order. Within an entry, writes go out in ascending port index.
- Duplicate destination addresses are written in index order, so the highest index wins.
- Simultaneous push and RETIRE pop: both take effect and count is unchanged. FIFO pointers wrap modulo BUF_DEPTH.

Test Plan:
- Single entry: id=2, rd={A0,A1,A2,A3,A4}, addrs={5,6,7,8,9}, gnt=1 -> rf_we for 5 cycles (addr 5..9, data A0..A4, rf_wid=2), then retire_valid with retire_id=2 on the 6th cycle after push.
- Zero skip: addrs={0,3,0,0,10} -> exactly 2 writes (addr 3/rd[1], then addr 10/rd[4]). All-zero addrs -> no rf_we, retire on the next cycle.
- Backpressure: rf_gnt held 0 for 4 cycles -> rf_we/addr/data stable across those cycles. Releasing gnt advances one port per cycle; retire is delayed by 4 cycles.
- Full buffer: BUF_DEPTH=2, gnt=0, push ids 1,2 -> ready=0. A third done with id=3 -> dropped, overflow=1. Releasing gnt -> ids 1 then 2 retire, id 3 never appears.
- Back-to-back: pushes on consecutive cycles (ids 4,5), gnt=1 -> writes for 4, retire 4, writes for 5, retire 5, with no idle cycle between.
- Reset mid-drain: rst asserted after the 2nd write of an entry -> next cycle rf_we=0, retire_valid=0, ready=1, overflow=0. No later output appears from the discarded entry.
